tile_fetch_arbiter: RTL
=======================

// Module: tile_fetch_arbiter
// PURPOSE
//  Shares one tile_data/tile ROM read path among NUM_REQ sprite/background requesters.
//  Uses round-robin arbitration and allows one outstanding fetch at a time.
//  Each fetch runs IDLE->ISSUE->WAIT and returns the 24-bit RGB with a one-hot ack.
//  A timeout flags fetches that never receive valid.
//  Sits between the pixel pipeline (paddles, ball, playfield) and the tile_data block.
// PARAMETERS
//  NUM_REQ   3   number of requesters (2..8)
//  TIMEOUT   16  WAIT cycles allowed before an error ack (>=2)
// PORTS
//  i_clk             in   1          system clock
//  i_rst_n           in   1          reset, synchronous, active-low
//  i_req             in   NUM_REQ    per-requester fetch request, held until its ack
//  i_req_tile_no     in   NUM_REQ*4  packed tile numbers; requester k at [4k+3:4k]
//  i_req_tile_x      in   NUM_REQ*2  packed pixel column within the tile
//  i_req_tile_y      in   NUM_REQ*2  packed pixel row within the tile
//  i_req_mirror      in   NUM_REQ*2  packed mirror code: 0 none, 1 H, 2 V, 3 VH
//  o_ack             out  NUM_REQ    one-hot, 1-cycle pulse: fetch for requester k done
//  o_rgb_data        out  24         fetched pixel; valid in the o_ack cycle, held after
//  o_err             out  1          high with o_ack when the fetch timed out
//  o_tile_no         out  4          to tile_data; granted fields, stable ISSUE..WAIT
//  o_tile_x          out  2          to tile_data
//  o_tile_y          out  2          to tile_data
//  o_mirror          out  2          to tile_data
//  o_tile_read       out  1          to tile_data read strobe; high for the ISSUE cycle only
//  i_tile_rgb        in   24         from tile_data o_rgb_data
//  i_tile_valid      in   1          from tile_data o_valid
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, last-grant pointer = NUM_REQ-1 (req 0 wins first).
//  - Eligibility: eligible = i_req & ~o_ack. The requester being acked this cycle is masked.
//  - IDLE, any eligible request:
//    - Pick the first eligible index after the last-grant pointer, wrapping.
//    - Register that index and its tile fields, update the pointer, go to ISSUE.
//  - ISSUE: o_tile_read=1 for exactly one cycle; o_tile_* driven from the registered fields.
//  - ISSUE/WAIT, i_tile_valid=1:
//    - Latch i_tile_rgb into o_rgb_data.
//    - Next cycle: o_ack[grant]=1, o_err=0, state IDLE.
//    - Valid is sampled in ISSUE too, so a 0-latency ROM is supported.
//  - WAIT timeout:
//    - Counter starts at 0 on WAIT entry; when it reaches TIMEOUT-1 without valid:
//    - Next cycle: o_ack[grant]=1, o_err=1, o_rgb_data=24'h0, state IDLE.
//  - Latency: 1-cycle ROM gives req seen (c0), read (c1), valid (c2), ack (c3).
//    New grant possible in c3; back-to-back fetches every 3 cycles.
//  - i_tile_valid in IDLE (stray or late after timeout) is ignored and o_rgb_data is unchanged.
//  - Requester drops i_req mid-fetch: the fetch still completes and the ack is still pulsed.
//    Fields are registered, so input changes after the grant have no effect.
//  - Simultaneous valid and timeout in the same WAIT cycle: valid wins, o_err=0.
//  - o_tile_* hold their last granted values in IDLE; they are meaningful only with o_tile_read.
//  - Reset mid-fetch: immediate return to reset state, no ack emitted.
//  - Widths: timeout counter is clog2(TIMEOUT) bits; grant index is clog2(NUM_REQ) bits.
// STRUCTURE
//  - Shared package (tile_pkg):
//    - Constants TILE_NO_W=4, TILE_XY_W=2, MIRROR_W=2, RGB_W=24.
//    - Mirror codes MIRROR_NO/H/V/VH.
//    - State encoding ST_IDLE/ST_ISSUE/ST_WAIT.
//  - Sub-module rr_pick: combinational round-robin picker.
//    - Inputs: eligible vector, pointer. Outputs: found, index.
//    - Reusable for future bus sharing.
//  - Top holds the FSM, field registers, timeout counter and output registers.
// TESTING
//  1 Single req: i_req=3'b001, tile 5, x=2, y=1, mirror 0, ROM valid 1 cycle after read
//    -> o_tile_read at c1 with tile_no=5; o_ack=3'b001 at c3; o_rgb_data=ROM word; o_err=0.
//  2 All three requesting continuously, each dropping req after its ack
//    -> ack order 001, 010, 100, one every 3 cycles.
//  3 Requester 1 held high, requester 2 requesting
//    -> grants alternate 1, 2, 1, 2; no starvation; acked requester never re-granted in its ack cycle.
//  4 Valid never asserted, TIMEOUT=16
//    -> o_ack pulses 17 cycles after ISSUE with o_err=1 and o_rgb_data=0.
//    -> a valid injected 2 cycles later is ignored.
//  5 Zero-latency ROM (valid in the ISSUE cycle) -> ack at c2; mirror=3 passes to o_mirror unchanged.
//  6 i_rst_n low during WAIT, then high -> no ack; outputs 0; next req 0 fetch starts from IDLE.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared constants and encodings for the tile fetch path between the pixel
// pipeline requesters and the tile_data ROM.
package tile_pkg;

  localparam int TILE_NO_W = 4;
  localparam int TILE_XY_W = 2;
  localparam int MIRROR_W  = 2;
  localparam int RGB_W     = 24;

  localparam logic [MIRROR_W-1:0] MIRROR_NO = 2'd0;
  localparam logic [MIRROR_W-1:0] MIRROR_H  = 2'd1;
  localparam logic [MIRROR_W-1:0] MIRROR_V  = 2'd2;
  localparam logic [MIRROR_W-1:0] MIRROR_VH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/tile_fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first eligible index strictly
// after the pointer, wrapping around.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
    int s;
    s = (int'(p) + off) % N;
    return IW'(s);
  endfunction

  // Scan farthest-first so the nearest eligible index after the pointer wins.
  always_comb begin
    o_found = 1'b0;
    o_index = {IW{1'b0}};
    for (int i = N; i >= 1; i--) begin
      o_found = o_found | i_eligible[wrap_idx(i_ptr, i)];
      o_index = i_eligible[wrap_idx(i_ptr, i)] ? wrap_idx(i_ptr, i) : o_index;
    end
  end

endmodule

// File: rtl/tile_fetch_arbiter.sv
// Round-robin arbiter sharing one tile_data read path; one outstanding fetch,
// IDLE->ISSUE->WAIT, one-hot ack with RGB, and a WAIT timeout that acks with error.
module tile_fetch_arbiter
  import tile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*TILE_NO_W-1:0]  i_req_tile_no,
  input  logic [NUM_REQ*TILE_XY_W-1:0]  i_req_tile_x,
  input  logic [NUM_REQ*TILE_XY_W-1:0]  i_req_tile_y,
  input  logic [NUM_REQ*MIRROR_W-1:0]   i_req_mirror,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [RGB_W-1:0]              o_rgb_data,
  output logic                          o_err,
  output logic [TILE_NO_W-1:0]          o_tile_no,
  output logic [TILE_XY_W-1:0]          o_tile_x,
  output logic [TILE_XY_W-1:0]          o_tile_y,
  output logic [MIRROR_W-1:0]           o_mirror,
  output logic                          o_tile_read,
  input  logic [RGB_W-1:0]              i_tile_rgb,
  input  logic                          i_tile_valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TILE_NO_W-1:0]   tile_no_q, tile_no_d;
  logic [TILE_XY_W-1:0]   tile_x_q, tile_x_d;
  logic [TILE_XY_W-1:0]   tile_y_q, tile_y_d;
  logic [MIRROR_W-1:0]    mirror_q, mirror_d;
  logic [RGB_W-1:0]       rgb_q, rgb_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   tile_read_q, tile_read_d;

  logic [NUM_REQ-1:0]     eligible_s;
  logic                   pick_found_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [TILE_NO_W-1:0]   req_tile_no_s [NUM_REQ];
  logic [TILE_XY_W-1:0]   req_tile_x_s  [NUM_REQ];
  logic [TILE_XY_W-1:0]   req_tile_y_s  [NUM_REQ];
  logic [MIRROR_W-1:0]    req_mirror_s  [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_tile_no_s[g] = i_req_tile_no[g*TILE_NO_W +: TILE_NO_W];
    assign req_tile_x_s[g]  = i_req_tile_x[g*TILE_XY_W +: TILE_XY_W];
    assign req_tile_y_s[g]  = i_req_tile_y[g*TILE_XY_W +: TILE_XY_W];
    assign req_mirror_s[g]  = i_req_mirror[g*MIRROR_W +: MIRROR_W];
  end

  // The requester being acked this cycle cannot win again until next cycle.
  assign eligible_s = i_req & ~ack_q;

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_rr_pick (
    .i_eligible (eligible_s),
    .i_ptr      (ptr_q),
    .o_found    (pick_found_s),
    .o_index    (pick_idx_s)
  );

  // Next-state, field capture, timeout count and registered-output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    tile_no_d   = tile_no_q;
    tile_x_d    = tile_x_q;
    tile_y_d    = tile_y_q;
    mirror_d    = mirror_q;
    rgb_d       = rgb_q;
    ack_d       = {NUM_REQ{1'b0}};
    err_d       = 1'b0;
    tile_read_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_d     = pick_idx_s;
          ptr_d       = pick_idx_s;
          tile_no_d   = req_tile_no_s[pick_idx_s];
          tile_x_d    = req_tile_x_s[pick_idx_s];
          tile_y_d    = req_tile_y_s[pick_idx_s];
          mirror_d    = req_mirror_s[pick_idx_s];
          tile_read_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d = {CNT_W{1'b0}};
        if (i_tile_valid) begin
          rgb_d   = i_tile_rgb;
          ack_d   = onehot(grant_q);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Valid takes priority over a timeout landing in the same cycle.
        if (i_tile_valid) begin
          rgb_d   = i_tile_rgb;
          ack_d   = onehot(grant_q);
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rgb_d   = {RGB_W{1'b0}};
          ack_d   = onehot(grant_q);
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_q     <= {IDX_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      tile_no_q   <= {TILE_NO_W{1'b0}};
      tile_x_q    <= {TILE_XY_W{1'b0}};
      tile_y_q    <= {TILE_XY_W{1'b0}};
      mirror_q    <= MIRROR_NO;
      rgb_q       <= {RGB_W{1'b0}};
      ack_q       <= {NUM_REQ{1'b0}};
      err_q       <= 1'b0;
      tile_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      tile_no_q   <= tile_no_d;
      tile_x_q    <= tile_x_d;
      tile_y_q    <= tile_y_d;
      mirror_q    <= mirror_d;
      rgb_q       <= rgb_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      tile_read_q <= tile_read_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_rgb_data  = rgb_q;
  assign o_tile_no   = tile_no_q;
  assign o_tile_x    = tile_x_q;
  assign o_tile_y    = tile_y_q;
  assign o_mirror    = mirror_q;
  assign o_tile_read = tile_read_q;

endmodule
